// File: rtl/mem_rr_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the round-robin memory arbiter.
// Latency: n/a (wiring only). Backpressure: mem_gnt_i stalls the memory side; gnt_o stalls requesters.
// Modports: slave = arbiter view, master = view of the environment (requesters + memory).
// Optional lock_i exists only when MEM_ARB_LOCK_EN is defined.
interface mem_rr_arbiter_if #(
   parameter int NUM_REQ   = 2,
   parameter int ADDR_SIZE = 32,
   parameter int DATA_SIZE = 32
);
   localparam int STRB_SIZE = DATA_SIZE / 8;

   // requester side, requester k occupies slice k of each packed bus
   logic [NUM_REQ-1:0]           req_i;
   logic [NUM_REQ*ADDR_SIZE-1:0] addr_i;
   logic [NUM_REQ*DATA_SIZE-1:0] wdata_i;
   logic [NUM_REQ*STRB_SIZE-1:0] strb_i;
   logic [NUM_REQ-1:0]           we_i;
   logic [NUM_REQ-1:0]           gnt_o;
   logic [NUM_REQ-1:0]           rvalid_o;
   logic [DATA_SIZE-1:0]         rdata_o;
`ifdef MEM_ARB_LOCK_EN
   logic [NUM_REQ-1:0]           lock_i;
`endif

   // memory side
   logic                         mem_req_o;
   logic                         mem_gnt_i;
   logic [ADDR_SIZE-1:0]         mem_addr_o;
   logic [DATA_SIZE-1:0]         mem_wdata_o;
   logic [STRB_SIZE-1:0]         mem_strb_o;
   logic                         mem_we_o;
   logic [DATA_SIZE-1:0]         mem_rdata_i;

   modport slave (
`ifdef MEM_ARB_LOCK_EN
      input  lock_i,
`endif
      input  req_i, addr_i, wdata_i, strb_i, we_i, mem_gnt_i, mem_rdata_i,
      output gnt_o, rvalid_o, rdata_o,
             mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o, mem_we_o
   );

   modport master (
`ifdef MEM_ARB_LOCK_EN
      output lock_i,
`endif
      output req_i, addr_i, wdata_i, strb_i, we_i, mem_gnt_i, mem_rdata_i,
      input  gnt_o, rvalid_o, rdata_o,
             mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o, mem_we_o
   );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
// Latency: request forwarded to memory in the same cycle; rvalid/rdata steered back 1 cycle after grant.
// Backpressure: mem_gnt_i low withholds every grant and freezes the priority pointer.
// Ports: clk_i, rst_i (synchronous, active high), bus (mem_rr_arbiter_if.slave: requester
//   req/addr/wdata/strb/we in, gnt/rvalid/rdata out; memory req/addr/wdata/strb/we out, gnt/rdata in).
// Optional: define MEM_ARB_LOCK_EN to add lock_i and let a locked requester keep the memory.
module mem_rr_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int ADDR_SIZE = 32,
   parameter int DATA_SIZE = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   mem_rr_arbiter_if.slave  bus
);
   localparam int IDX_W     = $clog2(NUM_REQ);
   localparam int STRB_SIZE = DATA_SIZE / 8;

   logic [IDX_W-1:0]   last_q, last_d;
   logic               rvalid_q, rvalid_d;
   logic [IDX_W-1:0]   rid_q, rid_d;

   logic [NUM_REQ-1:0] req_eff;
   logic               win_vld;
   logic [IDX_W-1:0]   win_idx;
   logic               grant;

`ifdef MEM_ARB_LOCK_EN
   logic               locked_q, locked_d;
   logic [IDX_W-1:0]   lock_id_q, lock_id_d;
   logic               lock_hold;

   // The lock only holds while its owner still asserts lock_i, so the cycle in
   // which lock_i drops is already arbitrated round-robin from last_q.
   always_comb begin
      lock_hold = locked_q & bus.lock_i[lock_id_q];
      req_eff   = lock_hold ? (bus.req_i & (NUM_REQ'(1) << lock_id_q)) : bus.req_i;
   end
`else
   always_comb begin
      req_eff = bus.req_i;
   end
`endif

   // Scan offsets from NUM_REQ down to 1 so the smallest offset after last_q
   // is assigned last and therefore wins.
   always_comb begin
      logic [IDX_W-1:0] idx;
      win_vld = 1'b0;
      win_idx = '0;
      idx     = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         idx = IDX_W'((int'(last_q) + off) % NUM_REQ);
         if (req_eff[idx]) begin
            win_vld = 1'b1;
            win_idx = idx;
         end
      end
   end

   assign grant = win_vld & bus.mem_gnt_i & ~rst_i;

   // Outputs are forced idle combinationally during reset, not only via the flops.
   always_comb begin
      bus.mem_req_o   = win_vld & ~rst_i;
      bus.gnt_o       = grant ? (NUM_REQ'(1) << win_idx) : '0;
      bus.mem_addr_o  = win_vld ? bus.addr_i[win_idx*ADDR_SIZE +: ADDR_SIZE]  : '0;
      bus.mem_wdata_o = win_vld ? bus.wdata_i[win_idx*DATA_SIZE +: DATA_SIZE] : '0;
      bus.mem_strb_o  = win_vld ? bus.strb_i[win_idx*STRB_SIZE +: STRB_SIZE]  : '0;
      bus.mem_we_o    = win_vld ? bus.we_i[win_idx] : 1'b0;
      bus.rvalid_o    = (rvalid_q & ~rst_i) ? (NUM_REQ'(1) << rid_q) : '0;
      bus.rdata_o     = bus.mem_rdata_i;
   end

   // rvalid/rid are rewritten every cycle, so back-to-back grants each get
   // their own response slot; writes are acknowledged the same way.
   always_comb begin
      last_d   = grant ? win_idx : last_q;
      rvalid_d = grant;
      rid_d    = grant ? win_idx : rid_q;
`ifdef MEM_ARB_LOCK_EN
      locked_d  = locked_q;
      lock_id_d = lock_id_q;
      if (grant && bus.lock_i[win_idx]) begin
         locked_d  = 1'b1;
         lock_id_d = win_idx;
      end else if (locked_q && !bus.lock_i[lock_id_q]) begin
         locked_d  = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q    <= IDX_W'(NUM_REQ - 1);
         rvalid_q  <= 1'b0;
         rid_q     <= '0;
`ifdef MEM_ARB_LOCK_EN
         locked_q  <= 1'b0;
         lock_id_q <= '0;
`endif
      end else begin
         last_q    <= last_d;
         rvalid_q  <= rvalid_d;
         rid_q     <= rid_d;
`ifdef MEM_ARB_LOCK_EN
         locked_q  <= locked_d;
         lock_id_q <= lock_id_d;
`endif
      end
   end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with two requesters.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Lock scenario is compiled in only with MEM_ARB_LOCK_EN.
module tb_mem_rr_arbiter;
   localparam int NR = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_rr_arbiter_if #(.NUM_REQ(NR), .ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

   mem_rr_arbiter #(.NUM_REQ(NR), .ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle of stimulus, applied at the falling edge.
   task automatic step(input logic r, input logic [NR-1:0] req, input logic [NR-1:0] we,
                       input logic mgnt, input logic [DW-1:0] rdata);
      @(negedge clk);
      rst             = r;
      bus.req_i       = req;
      bus.we_i        = we;
      bus.mem_gnt_i   = mgnt;
      bus.mem_rdata_i = rdata;
      #1;
   endtask

   logic [NR-1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [NR-1:0] prev_g;

   initial begin
      rst             = 1'b1;
      bus.req_i       = '0;
      bus.we_i        = '0;
      bus.mem_gnt_i   = 1'b0;
      bus.mem_rdata_i = '0;
      bus.addr_i      = {32'h0000_0100, 32'h0000_0040};
      bus.wdata_i     = {32'hCAFE_F00D, 32'h1234_5678};
      bus.strb_i      = {4'b1111, 4'b0011};
`ifdef MEM_ARB_LOCK_EN
      bus.lock_i      = '0;
`endif

      // reset: outputs idle even with requests and a ready memory
      step(1'b1, 2'b11, 2'b00, 1'b1, 32'hA5A5_A5A5);
      check("rst_mem_req", bus.mem_req_o, 1'b0);
      check("rst_gnt",     bus.gnt_o, 2'b00);
      check("rst_rvalid",  bus.rvalid_o, 2'b00);
      check("rst_rdata",   bus.rdata_o, 32'hA5A5_A5A5);
      step(1'b1, 2'b11, 2'b00, 1'b1, 32'h0);
      check("rst_gnt2",    bus.gnt_o, 2'b00);

      // round robin with both requesting, response one cycle later
      prev_g = 2'b00;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 2'b11, 2'b00, 1'b1, 32'h1000 + i);
         check("rr_gnt",    bus.gnt_o, exp_g[i]);
         check("rr_addr",   bus.mem_addr_o, (exp_g[i] == 2'b01) ? 32'h40 : 32'h100);
         check("rr_rvalid", bus.rvalid_o, prev_g);
         check("rr_rdata",  bus.rdata_o, 32'h1000 + i);
         prev_g = exp_g[i];
      end

      // single read from requester 1 right after it was last granted
      step(1'b0, 2'b10, 2'b00, 1'b1, 32'h0);
      check("rd_gnt",    bus.gnt_o, 2'b10);
      check("rd_addr",   bus.mem_addr_o, 32'h100);
      check("rd_we",     bus.mem_we_o, 1'b0);
      check("rd_rvalid_prev", bus.rvalid_o, 2'b10);
      step(1'b0, 2'b00, 2'b00, 1'b1, 32'hDEAD_BEEF);
      check("rd_rvalid", bus.rvalid_o, 2'b10);
      check("rd_rdata",  bus.rdata_o, 32'hDEAD_BEEF);
      check("idle_req",  bus.mem_req_o, 1'b0);
      check("idle_addr", bus.mem_addr_o, 32'h0);
      check("idle_gnt",  bus.gnt_o, 2'b00);

      // memory stall: no grant, pointer frozen
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 2'b11, 2'b00, 1'b0, 32'h0);
         check("stall_gnt",     bus.gnt_o, 2'b00);
         check("stall_mem_req", bus.mem_req_o, 1'b1);
         check("stall_rvalid",  bus.rvalid_o, 2'b00);
      end
      step(1'b0, 2'b11, 2'b00, 1'b1, 32'h0);
      check("stall_release_gnt", bus.gnt_o, 2'b01);
      step(1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
      check("stall_rvalid_after", bus.rvalid_o, 2'b01);

      // write from requester 0
      step(1'b0, 2'b01, 2'b01, 1'b1, 32'h0);
      check("wr_gnt",    bus.gnt_o, 2'b01);
      check("wr_we",     bus.mem_we_o, 1'b1);
      check("wr_strb",   bus.mem_strb_o, 4'b0011);
      check("wr_wdata",  bus.mem_wdata_o, 32'h1234_5678);
      check("wr_addr",   bus.mem_addr_o, 32'h40);
      check("wr_rvalid_now", bus.rvalid_o, 2'b00);
      step(1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
      check("wr_ack",    bus.rvalid_o, 2'b01);

      // reset right after a grant drops the response and restores priority
      step(1'b0, 2'b01, 2'b00, 1'b1, 32'h0);
      check("pre_rst_gnt", bus.gnt_o, 2'b01);
      step(1'b1, 2'b11, 2'b00, 1'b1, 32'h0);
      check("midrst_rvalid",  bus.rvalid_o, 2'b00);
      check("midrst_mem_req", bus.mem_req_o, 1'b0);
      step(1'b1, 2'b00, 2'b00, 1'b1, 32'h0);
      check("midrst_rvalid2", bus.rvalid_o, 2'b00);
      step(1'b0, 2'b11, 2'b00, 1'b1, 32'h0);
      check("post_rst_gnt",    bus.gnt_o, 2'b01);
      check("post_rst_rvalid", bus.rvalid_o, 2'b00);

`ifdef MEM_ARB_LOCK_EN
      // requester 1 locks the memory for three grants, then releases
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.req_i     = 2'b11;
         bus.lock_i    = 2'b10;
         bus.mem_gnt_i = 1'b1;
         #1;
         check("lock_gnt", bus.gnt_o, 2'b10);
      end
      @(negedge clk);
      bus.lock_i = 2'b00;
      #1;
      check("unlock_gnt", bus.gnt_o, 2'b01);
`endif

      step(1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
